// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: turns CPU microcycle strobes into registered SRAM/ROM/IO bus controls
// and owns the RAM/ROM bank registers. Define BUS_CYCLE_CHECK_EN to build the strobe-order checker.
module bus_cycle_ctrl #(
   parameter logic [7:0] IO_PAGE      = 8'h9F,
   parameter logic [7:0] RAMBANK_INIT = 8'h00,
   parameter logic [4:0] ROMBANK_INIT = 5'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        latch_ad,
   input  logic        setup_cs,
   input  logic        release_wr,
   input  logic        release_cs,
   input  logic [15:0] cpu_ab,
   input  logic        cpu_rwn,
   input  logic [7:0]  cpu_db,
   output logic [20:0] mem_ab,
   output logic        ram_csn,
   output logic        rom_csn,
   output logic        io_csn,
   output logic        mem_rdn,
   output logic        mem_wrn,
   output logic        breg_rd,
   output logic [7:0]  bank_q,
   output logic [7:0]  rambank,
   output logic [4:0]  rombank,
   output logic        seq_err
);

   typedef enum logic [1:0] {IDLE, DECODE, ACTIVE, WHOLD} state_t;
   typedef enum logic [1:0] {REG_BREG, REG_RAM, REG_IO, REG_ROM} region_t;

   state_t      state;
   region_t     region;
   region_t     region_d;
   logic [15:0] a_q;
   logic        rw_q;
   logic        first_q;
   logic [20:0] ab_d;

   // Address map decode of the latched CPU address; breg wins over everything.
   always_comb begin
      region_d = REG_RAM;
      ab_d     = {5'b00000, a_q};
      if (a_q[15:1] == 15'd0) begin
         region_d = REG_BREG;
      end else if (a_q[15:8] == IO_PAGE) begin
         region_d = REG_IO;
      end else if (a_q[15:14] == 2'b11) begin
         region_d = REG_ROM;
         ab_d     = {2'b00, rombank, a_q[13:0]};
      end else if (a_q[15:13] == 3'b101) begin
         region_d = REG_RAM;
         ab_d     = {rambank, a_q[12:0]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         region  <= REG_RAM;
         a_q     <= 16'h0000;
         rw_q    <= 1'b1;
         first_q <= 1'b0;
         mem_ab  <= 21'd0;
         ram_csn <= 1'b1;
         rom_csn <= 1'b1;
         io_csn  <= 1'b1;
         mem_rdn <= 1'b1;
         mem_wrn <= 1'b1;
         breg_rd <= 1'b0;
         bank_q  <= RAMBANK_INIT;
         rambank <= RAMBANK_INIT;
         rombank <= ROMBANK_INIT;
      end else begin
         bank_q <= a_q[0] ? {3'b000, rombank} : rambank;
         case (state)
            IDLE: begin
               if (setup_cs && latch_ad) begin
                  a_q   <= cpu_ab;
                  rw_q  <= cpu_rwn;
                  state <= DECODE;
               end
            end
            DECODE: begin
               region  <= region_d;
               first_q <= 1'b1;
               state   <= ACTIVE;
               if (region_d == REG_BREG) begin
                  breg_rd <= rw_q;
               end else begin
                  mem_ab  <= ab_d;
                  mem_rdn <= ~rw_q;
                  ram_csn <= (region_d != REG_RAM);
                  rom_csn <= (region_d != REG_ROM);
                  io_csn  <= (region_d != REG_IO);
               end
            end
            ACTIVE: begin
               first_q <= 1'b0;
               if (release_wr && !rw_q && region == REG_BREG) begin
                  if (a_q[0]) rombank <= cpu_db[4:0];
                  else        rambank <= cpu_db;
               end
               // release_cs wins: it ends the cycle and also cancels a write not yet strobed.
               if (release_cs) begin
                  ram_csn <= 1'b1;
                  rom_csn <= 1'b1;
                  io_csn  <= 1'b1;
                  mem_rdn <= 1'b1;
                  mem_wrn <= 1'b1;
                  breg_rd <= 1'b0;
                  state   <= IDLE;
               end else if (release_wr) begin
                  mem_wrn <= 1'b1;
                  state   <= WHOLD;
               end else if (first_q && !rw_q && region != REG_BREG) begin
                  mem_wrn <= 1'b0;
               end
            end
            WHOLD: begin
               if (release_cs) begin
                  ram_csn <= 1'b1;
                  rom_csn <= 1'b1;
                  io_csn  <= 1'b1;
                  mem_rdn <= 1'b1;
                  mem_wrn <= 1'b1;
                  breg_rd <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BUS_CYCLE_CHECK_EN
   logic seq_bad;
   assign seq_bad = ((latch_ad | setup_cs) && (state != IDLE))
                 || ((release_wr | release_cs) && (state == IDLE || state == DECODE))
                 || (latch_ad != setup_cs);

   always_ff @(posedge clk) begin
      if (reset)        seq_err <= 1'b0;
      else if (seq_bad) seq_err <= 1'b1;
   end
`else
   assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: per-clock scoreboard of the bus outputs
// against a reference model of the address map and bank registers.
module tb_bus_cycle_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        latch_ad = 1'b0;
   logic        setup_cs = 1'b0;
   logic        release_wr = 1'b0;
   logic        release_cs = 1'b0;
   logic [15:0] cpu_ab = 16'h0000;
   logic        cpu_rwn = 1'b1;
   logic [7:0]  cpu_db = 8'h00;
   logic [20:0] mem_ab;
   logic        ram_csn, rom_csn, io_csn, mem_rdn, mem_wrn, breg_rd, seq_err;
   logic [7:0]  bank_q, rambank;
   logic [4:0]  rombank;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state.
   logic [20:0] m_ab;
   logic [7:0]  m_ram;
   logic [4:0]  m_rom;
   logic        m_err;

   // {seq_err, ram_csn, rom_csn, io_csn, mem_rdn, mem_wrn, breg_rd, mem_ab}
   logic [27:0] exp_q[$];

   bus_cycle_ctrl dut (
      .clk(clk), .reset(reset), .latch_ad(latch_ad), .setup_cs(setup_cs),
      .release_wr(release_wr), .release_cs(release_cs), .cpu_ab(cpu_ab),
      .cpu_rwn(cpu_rwn), .cpu_db(cpu_db), .mem_ab(mem_ab), .ram_csn(ram_csn),
      .rom_csn(rom_csn), .io_csn(io_csn), .mem_rdn(mem_rdn), .mem_wrn(mem_wrn),
      .breg_rd(breg_rd), .bank_q(bank_q), .rambank(rambank), .rombank(rombank),
      .seq_err(seq_err)
   );

   always #5 clk = ~clk;

   function automatic logic [27:0] observed();
      return {seq_err, ram_csn, rom_csn, io_csn, mem_rdn, mem_wrn, breg_rd, mem_ab};
   endfunction

   // Expected outputs while a cycle to address a is active (write strobe high).
   function automatic logic [26:0] act_vec(input logic [15:0] a, input logic rw);
      if (a <= 16'h0001)            return {5'b11111, rw, m_ab};
      else if (a[15:8] == 8'h9F)    return {3'b110, ~rw, 1'b1, 1'b0, 5'b00000, a};
      else if (a >= 16'hC000)       return {3'b101, ~rw, 1'b1, 1'b0, 2'b00, m_rom, a[13:0]};
      else if (a >= 16'hA000)       return {3'b011, ~rw, 1'b1, 1'b0, m_ram, a[12:0]};
      else                          return {3'b011, ~rw, 1'b1, 1'b0, 5'b00000, a};
   endfunction

   task automatic apply_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      latch_ad = 1'b0; setup_cs = 1'b0; release_wr = 1'b0; release_cs = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      m_ab = 21'd0; m_ram = 8'h00; m_rom = 5'h00; m_err = 1'b0;
   endtask

   // One CPU cycle at 6-clk timing; early_cs ends it with release_cs at t2 instead.
   task automatic bus_cycle(input string name, input logic [15:0] a, input logic rw,
                            input logic [7:0] d, input bit early_cs);
      logic [27:0] act, idle_old, idle_new, exp, got;
      bit breg;
      int n;
      act      = {m_err, act_vec(a, rw)};
      breg     = (a[15:1] == 15'd0);
      idle_old = {m_err, 6'b111110, m_ab};
      idle_new = {m_err, 6'b111110, act[20:0]};
      n        = early_cs ? 4 : 6;
      for (int t = 0; t < n; t++) begin
         @(posedge clk); #1;
         latch_ad = (t == 0);
         setup_cs = (t == 0);
         if (t == 0) begin
            cpu_ab = a; cpu_rwn = rw; cpu_db = d;
         end
         release_wr = (t == 3) && !early_cs;
         release_cs = early_cs ? (t == 2) : (t == 4);
         if (t < 2) exp = idle_old;
         else if (t == n - 1) exp = idle_new;
         else begin
            exp = act;
            if (t == 3 && !rw && !breg) exp[22] = 1'b0;
         end
         exp_q.push_back(exp);
         @(negedge clk);
         got = observed();
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
         end
         if (breg && rw && t == 3) begin
            n_checks++;
            if (bank_q !== (a[0] ? {3'b000, m_rom} : m_ram)) begin
               n_err++;
               $display("FAIL %s bank_q got=%h exp=%h", name, bank_q,
                        a[0] ? {3'b000, m_rom} : m_ram);
            end
         end
      end
      m_ab = act[20:0];
      if (!rw && breg && !early_cs) begin
         if (a[0]) m_rom = d[4:0];
         else      m_ram = d;
      end
   endtask

   task automatic check_banks(input string name);
      n_checks++;
      if (rambank !== m_ram || rombank !== m_rom) begin
         n_err++;
         $display("FAIL %s banks got=%h/%h exp=%h/%h", name, rambank, rombank, m_ram, m_rom);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      n_checks++;
      if (observed() !== {1'b0, 6'b111110, 21'd0} || bank_q !== 8'h00) begin
         n_err++;
         $display("FAIL reset outputs got=%h bank_q=%h exp=%h", observed(), bank_q,
                  {1'b0, 6'b111110, 21'd0});
      end
      check_banks("reset");
   endtask

   task automatic test_ram_read();
      bus_cycle("ram_read_1234", 16'h1234, 1'b1, 8'h00, 1'b0);
   endtask

   task automatic test_rombank();
      bus_cycle("wr_rombank", 16'h0001, 1'b0, 8'h05, 1'b0);
      check_banks("rombank_load");
      bus_cycle("rom_read_c123", 16'hC123, 1'b1, 8'h00, 1'b0);
   endtask

   task automatic test_rambank();
      bus_cycle("wr_rambank", 16'h0000, 1'b0, 8'h3C, 1'b0);
      check_banks("rambank_load");
      bus_cycle("banked_wr_a010", 16'hA010, 1'b0, 8'h77, 1'b0);
   endtask

   task automatic test_io_breg();
      bus_cycle("io_read_9f20", 16'h9F20, 1'b1, 8'h00, 1'b0);
      bus_cycle("breg_read_0000", 16'h0000, 1'b1, 8'h00, 1'b0);
      bus_cycle("breg_read_0001", 16'h0001, 1'b1, 8'h00, 1'b0);
   endtask

   task automatic test_cancel();
      bus_cycle("cancel_breg_wr", 16'h0000, 1'b0, 8'hAA, 1'b1);
      check_banks("cancel_no_load");
      bus_cycle("cancel_ram_wr", 16'h0100, 1'b0, 8'h55, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         bus_cycle("random_cycle", 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 255)), 1'b0);
      end
      check_banks("random_banks");
   endtask

   task automatic test_reset_mid_write();
      bus_cycle("set_rambank", 16'h0000, 1'b0, 8'h3C, 1'b0);
      for (int t = 0; t < 4; t++) begin
         @(posedge clk); #1;
         latch_ad = (t == 0);
         setup_cs = (t == 0);
         if (t == 0) begin
            cpu_ab = 16'hA010; cpu_rwn = 1'b0; cpu_db = 8'h11;
         end
         if (t == 3) reset = 1'b1;
      end
      @(negedge clk);
      n_checks++;
      if (mem_wrn !== 1'b0 || ram_csn !== 1'b0) begin
         n_err++;
         $display("FAIL mid_write_strobes got=%b%b exp=00", mem_wrn, ram_csn);
      end
      @(posedge clk); #1 reset = 1'b0;
      m_ab = 21'd0; m_ram = 8'h00; m_rom = 5'h00; m_err = 1'b0;
      @(negedge clk);
      n_checks++;
      if (observed() !== {1'b0, 6'b111110, 21'd0}) begin
         n_err++;
         $display("FAIL mid_write_reset got=%h exp=%h", observed(), {1'b0, 6'b111110, 21'd0});
      end
      check_banks("mid_write_reset_banks");
      bus_cycle("after_reset_read", 16'h1234, 1'b1, 8'h00, 1'b0);
      bus_cycle("after_reset_banked", 16'hA010, 1'b0, 8'h11, 1'b0);
   endtask

   task automatic test_seq_err();
      @(posedge clk); #1 release_wr = 1'b1;
      @(posedge clk); #1 release_wr = 1'b0;
`ifdef BUS_CYCLE_CHECK_EN
      m_err = 1'b1;
`endif
      @(negedge clk);
      n_checks++;
      if (seq_err !== m_err) begin
         n_err++;
         $display("FAIL seq_err_set got=%b exp=%b", seq_err, m_err);
      end
      bus_cycle("seq_err_sticky_1", 16'h2000, 1'b1, 8'h00, 1'b0);
      bus_cycle("seq_err_sticky_2", 16'h2001, 1'b0, 8'h9A, 1'b0);
      apply_reset();
      @(negedge clk);
      n_checks++;
      if (seq_err !== 1'b0) begin
         n_err++;
         $display("FAIL seq_err_clear got=%b exp=0", seq_err);
      end
   endtask

   initial begin
      test_reset();
      test_ram_read();
      test_rombank();
      test_rambank();
      test_io_breg();
      test_cancel();
      test_back_to_back();
      test_reset_mid_write();
      test_seq_err();
      if (exp_q.size() != 0) begin
         n_checks++;
         n_err++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
- Consumer side of the CPU microcycle strobes: turns latch_ad / setup_cs / release_wr / release_cs plus the 65C02 address and R/W into registered memory-bus controls.
- Decodes the 64K CPU space into fixed RAM, I/O, banked RAM and banked ROM; drives the physical address, chip selects, read and write strobes.
- Owns the RAM-bank and ROM-bank registers at CPU $0000/$0001.
- Sits between the phase generator and the SRAM/ROM/IO pins in the NORA top level.

Parameters:
- IO_PAGE, 8'h9F, CPU address high byte decoded as the I/O page.
- RAMBANK_INIT, 8'h00, reset value of the RAM bank register.
- ROMBANK_INIT, 5'h00, reset value of the ROM bank register.

Ports:
- clk  in  1  system clock, 48 MHz.
- reset  in  1  synchronous, active-high reset.
- latch_ad  in  1  one-clk strobe: capture CPU address and R/W.
- setup_cs  in  1  one-clk strobe: start a bus cycle, coincident with latch_ad.
- release_wr  in  1  one-clk strobe: end the write pulse.
- release_cs  in  1  one-clk strobe: end the bus cycle.
- cpu_ab  in  16  CPU address bus.
- cpu_rwn  in  1  CPU R/W (1 = read).
- cpu_db  in  8  CPU data bus (write data).
- mem_ab  out  21  physical address to SRAM/ROM.
- ram_csn  out  1  SRAM chip select, active low.
- rom_csn  out  1  ROM chip select, active low.
- io_csn  out  1  I/O page select, active low.
- mem_rdn  out  1  read strobe, active low.
- mem_wrn  out  1  write strobe, active low.
- breg_rd  out  1  high while a read of $0000/$0001 is active; the top level muxes bank_q onto the data bus.
- bank_q  out  8  rambank if latched A0=0, else {3'b000, rombank}.
- rambank  out  8  current RAM bank.
- rombank  out  5  current ROM bank.
- seq_err  out  1  sticky strobe-order error; see Optional Feature.

Behaviour:
- Reset: all *_csn, mem_rdn, mem_wrn = 1; mem_ab = 0; breg_rd = 0; rambank = RAMBANK_INIT; rombank = ROMBANK_INIT; seq_err = 0; FSM = IDLE. Reset mid-cycle aborts the cycle immediately with the same values.
- Every output is registered.
- FSM states: IDLE, DECODE, ACTIVE, WHOLD.
- IDLE:
  - On setup_cs & latch_ad: latch a_q = cpu_ab, rw_q = cpu_rwn; go to DECODE.
  - setup_cs without latch_ad is ignored.
- DECODE (one clk): compute the region from a_q and register it at the edge leaving DECODE.
  - $0000-$0001: breg region. No chip select. breg_rd = rw_q.
  - $0002-$9EFF and a_q[15:8] != IO_PAGE: ram_csn = 0; mem_ab = {5'b0, a_q}.
  - a_q[15:8] == IO_PAGE: io_csn = 0; mem_ab = {5'b0, a_q}.
  - $A000-$BFFF: ram_csn = 0; mem_ab = {rambank, a_q[12:0]}. Bank 0 aliases the low RAM by design.
  - $C000-$FFFF: rom_csn = 0; mem_ab = {2'b00, rombank, a_q[13:0]}.
  - Read: mem_rdn = 0 at the same edge, except the breg region.
  - Go to ACTIVE.
- ACTIVE:
  - Write (rw_q = 0), first clk in ACTIVE: mem_wrn = 0 at the next edge. Gives one clk of CS-to-WR setup. Not asserted for the breg region.
  - On release_wr: mem_wrn = 1 at the next edge.
    - If the region is breg: load cpu_db into rambank (a_q[0] = 0) or rombank[4:0] (a_q[0] = 1) at that same edge.
    - Go to WHOLD.
  - On release_cs: go to IDLE.
- WHOLD:
  - Hold CS with WR released.
  - On release_cs: go to IDLE.
- Cycle end, on entry to IDLE from ACTIVE or WHOLD: all *_csn = 1, mem_rdn = 1, mem_wrn = 1, breg_rd = 0 at the same edge. mem_ab holds its value.
- Simultaneous release_wr & release_cs in ACTIVE: the write is completed (bank load if breg), then IDLE; all strobes deassert at the same edge.
- release_cs in ACTIVE before mem_wrn has been asserted: the cycle is cancelled; no bank load.
- Stopped CPU (no strobes): the FSM stays IDLE; outputs hold their deasserted values.
- Nominal timing at 6 clk per CPU cycle:
  - Strobes in: latch_ad/setup_cs at t0; release_wr at t3; release_cs at t4.
  - CS/RD low from t2; WR low t3..t4; all deasserted at t5.

Optional Feature:
- Macro: BUS_CYCLE_CHECK_EN.
- Defined: seq_err is set and held until reset on any of:
  - latch_ad or setup_cs while not IDLE;
  - release_wr while IDLE or DECODE;
  - release_cs while IDLE or DECODE;
  - latch_ad without setup_cs or setup_cs without latch_ad.
- Defined, with seq_err set: the offending strobe is still processed per Behaviour.
- Not defined: seq_err tied to 0; no checker logic.

Test Plan:
- Read $1234 with 6-clk strobe timing -> ram_csn = 0 and mem_rdn = 0 from t2, mem_ab = 21'h001234, mem_wrn stays 1, all deassert at t5.
- Write 8'h05 to $0001, then read $C123 -> rombank = 5'h05; the write produces no CS and no mem_wrn; the read gives rom_csn = 0, mem_ab = 21'h014123.
- Write 8'h3C to $0000, then write $A010 -> rambank = 8'h3C; ram_csn = 0; mem_wrn low exactly one clk; mem_ab = {8'h3C, 13'h0010}.
- Read $9F20 -> io_csn = 0, ram_csn = 1, rom_csn = 1. Read $0000 after rambank = 8'h3C -> breg_rd = 1, bank_q = 8'h3C.
- reset asserted mid-write, in ACTIVE with mem_wrn = 0 -> next edge: all strobes 1, rambank = RAMBANK_INIT, FSM IDLE. The next normal cycle runs correctly.
- With BUS_CYCLE_CHECK_EN: release_wr while IDLE -> seq_err = 1 and stays 1 through further good cycles until reset. Without the macro: seq_err = 0 for the same stimulus.
